dmem_arbiter: RTL and testbench

- Two-port front end for the 64 KiB data memory (async read, sync byte-enable write).
- Port 0 is the core LSU; port 1 is the DMA/debug master. Each port uses a valid/ready request and a registered one-cycle response.
- Arbitrates access, checks alignment, generates byte enables and lane-shifted write data, and extracts and sign-extends load data.
- Sits between the LSU/DMA and the dmem instance.

---
 rtl/dmem_arbiter_pkg.sv | 68 ++++++
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter_lane_unit.sv | 32 +++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and lane helpers for the data-memory arbiter.
//   size_e      access size encoding (byte / half / word / illegal)
//   LANE_*      base byte-enable masks, shifted into place by offset
//   f_misaligned, f_byte_en, f_wlanes, f_load_ext: per-access lane math
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    // Illegal size counts as misaligned so one flag covers every error case.
    function automatic logic f_misaligned(size_e size, logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_byte_en(size_e size, logic [1:0] off);
        logic [3:0] en;
        case (size)
            SZ_B:    en = LANE_B << off;
            SZ_H:    en = LANE_H << {off[1], 1'b0};
            SZ_W:    en = LANE_W;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Replicate LSB-justified store data into every lane it could land in.
    function automatic logic [31:0] f_wlanes(size_e size, logic [31:0] wdata);
        logic [31:0] w;
        case (size)
            SZ_B:    w = {4{wdata[7:0]}};
            SZ_H:    w = {2{wdata[15:0]}};
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] f_load_ext(size_e size, logic [1:0] off, logic uns,
                                               logic [31:0] q);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = q[{off, 3'b000} +: 8];
        h = off[1] ? q[31:16] : q[15:0];
        case (size)
            SZ_B:    r = {{24{~uns & b[7]}}, b};
            SZ_H:    r = {{16{~uns & h[15]}}, h};
            SZ_W:    r = q;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//   req_valid/req_ready  valid/ready request handshake
//   req_we, req_addr, req_size, req_unsigned, req_wdata  request fields
//   rsp_valid, rsp_rdata, rsp_err  one-cycle registered response
// master: requester (LSU / DMA); slave: arbiter.
interface dmem_arbiter_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_arbiter_lane_unit.sv
// dmem_lane_unit: combinational lane logic for the granted request.
//   gnt, we, size, off, is_unsigned, wdata  granted request fields
//   mem_q   raw dmem read word
//   err     misaligned or illegal size
//   wren    byte enables (zero unless a legal granted store)
//   wlanes  store data replicated across lanes
//   rdata   extracted/extended load data (zero for stores and errors)
module dmem_lane_unit
    import dmem_arb_pkg::*;
(
    input  logic        gnt,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_q,
    output logic        err,
    output logic [3:0]  wren,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);

    size_e sz;

    assign sz     = size_e'(size);
    assign err    = f_misaligned(sz, off);
    assign wlanes = f_wlanes(sz, wdata);
    assign wren   = (gnt && we && !err) ? f_byte_en(sz, off) : 4'b0000;
    assign rdata  = (we || err) ? 32'h0 : f_load_ext(sz, off, is_unsigned, mem_q);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end for the 64 KiB data memory.
//   i_clk, i_reset   clock, asynchronous active-low reset
//   p0 (LSU), p1 (DMA/debug)  dmem_arbiter_if slave ports
//   mem_address, mem_data, mem_wren  drive to dmem; mem_q read data back
// Optional macro DMEM_ARB_STATS_EN adds stat_clr input and the 32-bit
// stat_grants0 / stat_grants1 / stat_conflicts counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    output logic [15:0]    mem_address,
    output logic [31:0]    mem_data,
    output logic [3:0]     mem_wren,
    input  logic [31:0]    mem_q
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic           stat_clr,
    output logic [31:0]    stat_grants0,
    output logic [31:0]    stat_grants1,
    output logic [31:0]    stat_conflicts
`endif
);

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             gnt0, gnt1, gnt_any;

    logic        sel_we, sel_unsigned;
    logic [15:0] sel_addr;
    logic [1:0]  sel_size;
    logic [31:0] sel_wdata;

    logic        lane_err;
    logic [3:0]  lane_wren;
    logic [31:0] lane_wlanes, lane_rdata;

    logic        rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
    logic [31:0] rsp0_rdata_q, rsp1_rdata_q;

    // Nothing is granted while reset is held, so no write can leak out.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_reset) begin
            if (p1.req_valid && (!p0.req_valid || starve_q >= StarveMax)) begin
                gnt1 = 1'b1;
            end else if (p0.req_valid) begin
                gnt0 = 1'b1;
            end
        end
    end

    assign gnt_any      = gnt0 | gnt1;
    assign p0.req_ready = gnt0;
    assign p1.req_ready = gnt1;

    always_comb begin
        starve_d = '0;
        if (p1.req_valid && !gnt1) begin
            starve_d = (starve_q >= StarveMax) ? starve_q : starve_q + 1'b1;
        end
    end

    always_comb begin
        sel_we       = p0.req_we;
        sel_unsigned = p0.req_unsigned;
        sel_addr     = p0.req_addr;
        sel_size     = p0.req_size;
        sel_wdata    = p0.req_wdata;
        if (gnt1) begin
            sel_we       = p1.req_we;
            sel_unsigned = p1.req_unsigned;
            sel_addr     = p1.req_addr;
            sel_size     = p1.req_size;
            sel_wdata    = p1.req_wdata;
        end
    end

    dmem_lane_unit u_lane (
        .gnt         (gnt_any),
        .we          (sel_we),
        .size        (sel_size),
        .off         (sel_addr[1:0]),
        .is_unsigned (sel_unsigned),
        .wdata       (sel_wdata),
        .mem_q       (mem_q),
        .err         (lane_err),
        .wren        (lane_wren),
        .wlanes      (lane_wlanes),
        .rdata       (lane_rdata)
    );

    assign mem_address = gnt_any ? sel_addr : 16'h0;
    assign mem_data    = gnt_any ? lane_wlanes : 32'h0;
    assign mem_wren    = lane_wren;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp0_rdata_q <= 32'h0;
            rsp1_rdata_q <= 32'h0;
        end else begin
            starve_q     <= starve_d;
            rsp0_valid_q <= gnt0;
            rsp1_valid_q <= gnt1;
            rsp0_err_q   <= gnt0 & lane_err;
            rsp1_err_q   <= gnt1 & lane_err;
            rsp0_rdata_q <= gnt0 ? lane_rdata : 32'h0;
            rsp1_rdata_q <= gnt1 ? lane_rdata : 32'h0;
        end
    end

    assign p0.rsp_valid = rsp0_valid_q;
    assign p0.rsp_err   = rsp0_err_q;
    assign p0.rsp_rdata = rsp0_rdata_q;
    assign p1.rsp_valid = rsp1_valid_q;
    assign p1.rsp_err   = rsp1_err_q;
    assign p1.rsp_rdata = rsp1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] grants0_q, grants1_q, conflicts_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            grants0_q   <= 32'h0;
            grants1_q   <= 32'h0;
            conflicts_q <= 32'h0;
        end else if (stat_clr) begin
            grants0_q   <= 32'h0;
            grants1_q   <= 32'h0;
            conflicts_q <= 32'h0;
        end else begin
            grants0_q   <= grants0_q + {31'h0, gnt0};
            grants1_q   <= grants1_q + {31'h0, gnt1};
            conflicts_q <= conflicts_q + {31'h0, p0.req_valid & p1.req_valid};
        end
    end

    assign stat_grants0   = grants0_q;
    assign stat_grants1   = grants1_q;
    assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized bench for dmem_arbiter with a
// byte-level reference memory and a request-level grant model.
module tb_dmem_arbiter;

    localparam int STARVE = 8;

    logic        i_clk;
    logic        i_reset;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic [3:0]  mem_wren;
    logic [31:0] mem_q;
`ifdef DMEM_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_grants0, stat_grants1, stat_conflicts;
`endif

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter #(
        .STARVE_LIMIT (STARVE),
        .CNT_W        (4)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .p0             (p0_if.slave),
        .p1             (p1_if.slave),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_wren       (mem_wren),
        .mem_q          (mem_q)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_grants0   (stat_grants0),
        .stat_grants1   (stat_grants1),
        .stat_conflicts (stat_conflicts)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural dmem: async read, byte-enable write on the clock edge.
    logic [31:0] mem_arr [0:16383];
    assign mem_q = mem_arr[mem_address[15:2]];
    always @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_wren[k]) mem_arr[mem_address[15:2]][8*k +: 8] <= mem_data[8*k +: 8];
        end
    end

    // Reference state
    logic [7:0]  ref_mem [0:65535];
    int          blocked;
    logic        exp_v [2];
    logic [31:0] exp_d [2];
    logic        exp_e [2];
    int          last_gnt;
    int          tot_grants;
    logic [3:0]  last_wren;
    logic [31:0] last_data;
    logic [31:0] last_rsp0;
    logic        last_err0;
    int          m_g0, m_g1, m_conf;
    logic        r_clr;

    // Request fields driven on each port
    logic        r_valid [2];
    logic        r_we    [2];
    logic [15:0] r_addr  [2];
    logic [1:0]  r_size  [2];
    logic        r_uns   [2];
    logic [31:0] r_wdata [2];

    int n_tests, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    // Little-endian assemble n bytes, then extend from the top byte.
    function automatic logic [31:0] ref_load(input int a, input int n, input logic uns);
        logic [31:0] v;
        v = 32'h0;
        for (int b = 0; b < n; b++) v = v | (32'(ref_mem[(a + b) & 16'hFFFF]) << (8 * b));
        if (!uns && n < 4 && v[8*n-1]) begin
            for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic set_req(input int p, input logic v, input logic we, input logic [15:0] a,
                           input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        r_valid[p] = v;
        r_we[p]    = we;
        r_addr[p]  = a;
        r_size[p]  = sz;
        r_uns[p]   = uns;
        r_wdata[p] = wd;
    endtask

    task automatic rand_req(input int p, input int pct_valid);
        logic [1:0] sz;
        int         a;
        sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(size_bytes(sz) - 1);
        set_req(p, ($urandom_range(0, 99) < pct_valid), 1'($urandom_range(0, 1)), 16'(a), sz,
                1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic apply_inputs();
        p0_if.req_valid    = r_valid[0];
        p0_if.req_we       = r_we[0];
        p0_if.req_addr     = r_addr[0];
        p0_if.req_size     = r_size[0];
        p0_if.req_unsigned = r_uns[0];
        p0_if.req_wdata    = r_wdata[0];
        p1_if.req_valid    = r_valid[1];
        p1_if.req_we       = r_we[1];
        p1_if.req_addr     = r_addr[1];
        p1_if.req_size     = r_size[1];
        p1_if.req_unsigned = r_uns[1];
        p1_if.req_wdata    = r_wdata[1];
`ifdef DMEM_ARB_STATS_EN
        stat_clr = r_clr;
`endif
    endtask

    task automatic model_reset();
        blocked  = 0;
        last_gnt = -1;
        m_g0 = 0; m_g1 = 0; m_conf = 0;
        tot_grants = 0;
        for (int p = 0; p < 2; p++) begin
            exp_v[p] = 1'b0; exp_d[p] = 32'h0; exp_e[p] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the
    // model at the edge, check responses at the following negedge.
    task automatic step();
        int          g, n, a;
        logic        e, we;
        logic [3:0]  ew;
        logic [31:0] ld;
        logic        obs_v [2];
        logic [31:0] obs_d [2];
        logic        obs_e [2];
        apply_inputs();
        #1;
        g = -1;
        if (r_valid[1] && (!r_valid[0] || blocked >= STARVE)) g = 1;
        else if (r_valid[0]) g = 0;
        check_eq("ready0", 32'(p0_if.req_ready), 32'(g == 0));
        check_eq("ready1", 32'(p1_if.req_ready), 32'(g == 1));
        last_wren = mem_wren;
        last_data = mem_data;
        ew = 4'b0; e = 1'b0; ld = 32'h0; we = 1'b0; n = 0; a = 0;
        if (g >= 0) begin
            a  = int'(r_addr[g]);
            n  = size_bytes(r_size[g]);
            we = r_we[g];
            e  = (n == 0) || (a % n != 0);
            check_eq("mem_address", 32'(mem_address), 32'(r_addr[g]));
            if (we && !e) begin
                for (int i = 0; i < 4; i++) begin
                    if ((a & ~3) + i >= a && (a & ~3) + i < a + n) ew[i] = 1'b1;
                    check_eq("mem_data_lane", 32'(mem_data[8*i +: 8]),
                             32'(r_wdata[g][8*(i % n) +: 8]));
                end
            end
            if (!we && !e) ld = ref_load(a, n, r_uns[g]);
        end
        check_eq("mem_wren", 32'(mem_wren), 32'(ew));
        @(posedge i_clk);
        for (int p = 0; p < 2; p++) begin
            exp_v[p] = (g == p); exp_d[p] = 32'h0; exp_e[p] = 1'b0;
        end
        if (g >= 0) begin
            exp_d[g] = ld;
            exp_e[g] = e;
            tot_grants++;
            if (we && !e) begin
                for (int b = 0; b < n; b++) ref_mem[(a + b) & 16'hFFFF] = r_wdata[g][8*b +: 8];
            end
        end
        if (r_valid[1] && g != 1) blocked = (blocked >= STARVE) ? STARVE : blocked + 1;
        else blocked = 0;
        if (r_clr) begin
            m_g0 = 0; m_g1 = 0; m_conf = 0;
        end else begin
            if (g == 0) m_g0++;
            if (g == 1) m_g1++;
            if (r_valid[0] && r_valid[1]) m_conf++;
        end
        last_gnt = g;
        @(negedge i_clk);
        obs_v[0] = p0_if.rsp_valid; obs_d[0] = p0_if.rsp_rdata; obs_e[0] = p0_if.rsp_err;
        obs_v[1] = p1_if.rsp_valid; obs_d[1] = p1_if.rsp_rdata; obs_e[1] = p1_if.rsp_err;
        last_rsp0 = obs_d[0];
        last_err0 = obs_e[0];
        for (int p = 0; p < 2; p++) begin
            check_eq("rsp_valid", 32'(obs_v[p]), 32'(exp_v[p]));
            if (exp_v[p]) begin
                check_eq("rsp_rdata", obs_d[p], exp_d[p]);
                check_eq("rsp_err", 32'(obs_e[p]), 32'(exp_e[p]));
            end
        end
`ifdef DMEM_ARB_STATS_EN
        check_eq("stat_grants0", stat_grants0, 32'(m_g0));
        check_eq("stat_grants1", stat_grants1, 32'(m_g1));
        check_eq("stat_conflicts", stat_conflicts, 32'(m_conf));
`endif
    endtask

    initial begin
        int first_p1, second_p1;
        n_tests = 0;
        n_fail  = 0;
        r_clr   = 1'b0;
        for (int i = 0; i < 16384; i++) mem_arr[i] = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h0;
        model_reset();

        // Reset state, with both ports requesting a store to prove gating.
        i_reset = 1'b0;
        set_req(0, 1'b1, 1'b1, 16'h0004, 2'd2, 1'b0, 32'h12345678);
        set_req(1, 1'b1, 1'b1, 16'h0008, 2'd2, 1'b0, 32'h9ABCDEF0);
        apply_inputs();
        repeat (2) @(negedge i_clk);
        check_eq("rst_rsp_valid0", 32'(p0_if.rsp_valid), 32'h0);
        check_eq("rst_rsp_valid1", 32'(p1_if.rsp_valid), 32'h0);
        check_eq("rst_rsp_rdata0", p0_if.rsp_rdata, 32'h0);
        check_eq("rst_rsp_err1", 32'(p1_if.rsp_err), 32'h0);
        check_eq("rst_mem_wren", 32'(mem_wren), 32'h0);
        check_eq("rst_mem_address", 32'(mem_address), 32'h0);
        check_eq("rst_mem_data", mem_data, 32'h0);
        check_eq("rst_ready0", 32'(p0_if.req_ready), 32'h0);
        i_reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
        step();

        // Store word then load it back the next cycle.
        set_req(0, 1'b1, 1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF);
        step();
        check_eq("sw_wren", 32'(last_wren), 32'hF);
        set_req(0, 1'b1, 1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        step();
        check_eq("lw_rdata", last_rsp0, 32'hDEADBEEF);
        check_eq("lw_err", 32'(last_err0), 32'h0);

        // Byte store, signed and unsigned byte loads.
        set_req(0, 1'b1, 1'b1, 16'h0013, 2'd0, 1'b0, 32'h000000A5);
        step();
        check_eq("sb_wren", 32'(last_wren), 32'h8);
        check_eq("sb_data", last_data, 32'hA5A5A5A5);
        set_req(0, 1'b1, 1'b0, 16'h0013, 2'd0, 1'b0, 32'h0);
        step();
        check_eq("lb_signed", last_rsp0, 32'hFFFFFFA5);
        set_req(0, 1'b1, 1'b0, 16'h0013, 2'd0, 1'b1, 32'h0);
        step();
        check_eq("lb_unsigned", last_rsp0, 32'h000000A5);

        // Alignment errors: misaligned half store, misaligned word load, size 11.
        set_req(0, 1'b1, 1'b1, 16'h0021, 2'd1, 1'b0, 32'h0000CAFE);
        step();
        check_eq("err_sh_wren", 32'(last_wren), 32'h0);
        check_eq("err_sh_err", 32'(last_err0), 32'h1);
        set_req(0, 1'b1, 1'b0, 16'h0022, 2'd2, 1'b0, 32'h0);
        step();
        check_eq("err_lw_err", 32'(last_err0), 32'h1);
        check_eq("err_lw_rdata", last_rsp0, 32'h0);
        set_req(0, 1'b1, 1'b1, 16'h0024, 2'd3, 1'b0, 32'h11111111);
        step();
        check_eq("err_ill_wren", 32'(last_wren), 32'h0);
        check_eq("err_ill_err", 32'(last_err0), 32'h1);

        // Starvation: both valid continuously; p1 forced in on cycle 9 and 18.
        first_p1  = 0;
        second_p1 = 0;
        set_req(1, 1'b1, 1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            set_req(0, 1'b1, 1'b0, 16'($urandom_range(0, 63)), 2'd0, 1'b0, 32'h0);
            step();
            if (last_gnt == 1) begin
                if (first_p1 == 0) first_p1 = c;
                else if (second_p1 == 0) second_p1 = c;
            end
        end
        check_eq("starve_first_p1", 32'(first_p1), 32'd9);
        check_eq("starve_second_p1", 32'(second_p1), 32'd18);
        set_req(0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
        step();

        // Async reset while a load is granted, right after a response cycle.
        set_req(0, 1'b1, 1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        step();
        apply_inputs();
        #1;
        i_reset = 1'b0;
        #1;
        check_eq("arst_rsp_valid0", 32'(p0_if.rsp_valid), 32'h0);
        check_eq("arst_wren", 32'(mem_wren), 32'h0);
        check_eq("arst_ready0", 32'(p0_if.req_ready), 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        model_reset();
        set_req(0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
        step();
        step();
        set_req(0, 1'b1, 1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        step();
        check_eq("arst_mem_kept", last_rsp0, 32'hA5ADBEEF);

`ifdef DMEM_ARB_STATS_EN
        // Five conflict cycles, then a clear pulse.
        set_req(1, 1'b1, 1'b0, 16'h0014, 2'd2, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            set_req(0, 1'b1, 1'b0, 16'($urandom_range(0, 15) * 4), 2'd2, 1'b0, 32'h0);
            step();
        end
        check_eq("stat_conf5", stat_conflicts, 32'd5);
        check_eq("stat_sum", stat_grants0 + stat_grants1, 32'(tot_grants));
        set_req(0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
        r_clr = 1'b1;
        step();
        r_clr = 1'b0;
        check_eq("stat_clr_g0", stat_grants0, 32'h0);
        check_eq("stat_clr_g1", stat_grants1, 32'h0);
        check_eq("stat_clr_conf", stat_conflicts, 32'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
`endif

        // Randomized traffic; a blocked requester holds its request.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(r_valid[p] && last_gnt != p)) rand_req(p, (p == 0) ? 70 : 55);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
